// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
// Purpose: the fetch FSM state encoding, the bubble word, the HALT opcode and
// the opcode field position within an instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    START    = 2'd0,
    FETCH    = 2'd1,
    BUFFERED = 2'd2,
    HALTED   = 2'd3
  } fetch_state_t;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;
  localparam int          OPCODE_MSB  = 15;
  localparam int          OPCODE_LSB  = 11;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry {instr, pc_plus2} holding register
// Purpose: parks one fetched word while decode is stalled.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture instr_in/pc_plus2_in and mark full
//   unload            hand the entry off and mark empty
//   clear             discard the entry (wins over load/unload)
//   instr, pc_plus2   stored entry
//   full              entry is valid
module fetch_skid_buf #(
  parameter int IW = 16,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          unload,
  input  logic          clear,
  input  logic [IW-1:0] instr_in,
  input  logic [PW-1:0] pc_plus2_in,
  output logic [IW-1:0] instr,
  output logic [PW-1:0] pc_plus2,
  output logic          full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      instr    <= '0;
      pc_plus2 <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      instr    <= instr_in;
      pc_plus2 <= pc_plus2_in;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
// Purpose: owns the PC, fetches from instruction memory with a ready handshake,
// parks one word in a skid buffer across decode stalls, applies redirects with
// flush and stops requesting after a HALT is fetched.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/imem_addr         fetch request and address (address is the PC)
//   imem_rdata/imem_ready      returned word, valid when ready is high
//   stall                      hold IF/ID
//   redirect/redirect_pc       taken branch/jump and its target
//   if_id_instr/_pc_plus2/_valid  IF/ID register contents
//   halted                     HALT fetched, no further requests
module fetch_stage #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = 16'h0000,
  parameter logic [4:0]             HALT_OPCODE = fetch_pkg::HALT_OPCODE,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = fetch_pkg::NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [PC_WIDTH-1:0]    if_id_pc_plus2,
  output logic                   if_id_valid,
  output logic                   halted
);
  import fetch_pkg::*;

  fetch_state_t             state;
  logic [PC_WIDTH-1:0]      pc;
  logic [PC_WIDTH-1:0]      pc_inc;
  logic [INSTR_WIDTH-1:0]   skid_instr;
  logic [PC_WIDTH-1:0]      skid_pc_plus2;
  logic                     skid_full;
  logic                     skid_load;
  logic                     skid_unload;

  assign imem_addr = pc;
  // Wraps modulo 2^PC_WIDTH by construction.
  assign pc_inc    = pc + PC_WIDTH'(2);

  // Redirect squashes any capture or hand-off in the same cycle.
  assign skid_load   = (state == FETCH) && imem_ready && stall && !redirect;
  assign skid_unload = (state == BUFFERED) && skid_full && !stall && !redirect;

  fetch_skid_buf #(
    .IW (INSTR_WIDTH),
    .PW (PC_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (skid_load),
    .unload      (skid_unload),
    .clear       (redirect),
    .instr_in    (imem_rdata),
    .pc_plus2_in (pc_inc),
    .instr       (skid_instr),
    .pc_plus2    (skid_pc_plus2),
    .full        (skid_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= START;
      pc             <= RESET_PC;
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus2 <= '0;
      if_id_valid    <= 1'b0;
      halted         <= 1'b0;
      imem_req       <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      state       <= FETCH;
      imem_req    <= 1'b1;
    end else begin
      case (state)
        START: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_inc;
            if (stall) begin
              state    <= BUFFERED;
              imem_req <= 1'b0;
            end else begin
              if_id_instr    <= imem_rdata;
              if_id_pc_plus2 <= pc_inc;
              if_id_valid    <= 1'b1;
              if (opcode_of(imem_rdata) == HALT_OPCODE) begin
                state    <= HALTED;
                halted   <= 1'b1;
                imem_req <= 1'b0;
              end
            end
          end else if (!stall) begin
            // Memory wait: decode sees a bubble rather than a repeat.
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        BUFFERED: begin
          if (!stall && skid_full) begin
            if_id_instr    <= skid_instr;
            if_id_pc_plus2 <= skid_pc_plus2;
            if_id_valid    <= 1'b1;
            if (opcode_of(skid_instr) == HALT_OPCODE) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (!stall) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined core.
- Directly upstream of the decode/control block: if_id_instr[15:11] is the opcode that block decodes.
- Owns the PC, runs a ready-based handshake to instruction memory, and holds one fetched word in a skid buffer during decode stalls.
- Applies branch/jump redirects with flush, and stops issuing after fetching HALT.

Parameters:
- PC_WIDTH, 16, PC and address width.
- INSTR_WIDTH, 16, instruction width.
- RESET_PC, 16'h0000, PC after reset.
- HALT_OPCODE, 5'b00000, opcode that stops fetch.
- NOP_INSTR, 16'h0800, bubble instruction (opcode 5'b00001).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  16  fetch address; equals PC.
- imem_rdata  in  16  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory completes the request this cycle.
- stall  in  1  hazard unit: hold IF/ID.
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  16  new PC on redirect.
- if_id_instr  out  16  registered instruction to decode.
- if_id_pc_plus2  out  16  registered PC+2 of that instruction, used for JAL/JALR link and branch target.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  HALT fetched; no further requests.

Behaviour:
- Reset values: pc=RESET_PC, state=START, if_id_instr=NOP_INSTR, if_id_pc_plus2=0, if_id_valid=0, halted=0, imem_req=0, skid buffer empty.
- Reset is asynchronous: asserting rst_n mid-fetch or mid-stall forces all reset values immediately and discards any outstanding request.

State machine and outputs:
- States: START, FETCH, BUFFERED, HALTED.
- imem_req=1 only in FETCH. imem_addr=pc at all times.
- START -> FETCH on the first clock after reset deasserts.

FETCH, imem_ready=1, stall=0:
- IF/ID <= {imem_rdata, pc+2, valid=1}.
- pc <= pc+2.
- If imem_rdata[15:11]==HALT_OPCODE: go to HALTED and set halted=1. Otherwise stay in FETCH.
- Result is visible in IF/ID one cycle after the ready cycle; sustained throughput is one instruction per cycle.

FETCH, imem_ready=1, stall=1:
- Capture {imem_rdata, pc+2} into the skid buffer.
- pc <= pc+2.
- IF/ID holds its current contents.
- Go to BUFFERED; imem_req drops.

FETCH, imem_ready=0:
- pc, imem_addr and imem_req are held stable.
- If stall=0: IF/ID <= bubble (NOP_INSTR, valid=0).
- If stall=1: IF/ID holds.

BUFFERED:
- stall=1: hold everything.
- stall=0: IF/ID <= skid contents with valid=1; skid buffer empties.
- Next state: HALTED if the skid opcode is HALT, otherwise FETCH.

HALTED:
- imem_req=0 and halted=1.
- IF/ID drains: it becomes a bubble once stall=0.
- Leaves HALTED only on redirect or reset.

Redirect (highest priority, any state including HALTED and BUFFERED):
- pc <= redirect_pc.
- IF/ID <= bubble; skid buffer is discarded.
- halted <= 0; next state FETCH.
- A concurrent imem_ready is ignored, and a HALT in the redirect shadow is squashed.
- redirect overrides a concurrent stall.

Width rules:
- pc+2 wraps modulo 2^16: 16'hFFFE -> 16'h0000.
- redirect_pc is taken unaltered; bit 0 is not masked.

Decomposition:
- Package fetch_pkg: state enum {START, FETCH, BUFFERED, HALTED}, NOP_INSTR, HALT_OPCODE, OPCODE_MSB=15, OPCODE_LSB=11.
- One sub-module: fetch_skid_buf. It is a single-entry {instr, pc_plus2} register with load, unload and clear controls, plus a full flag.

Test Plan:
- Reset release, memory always ready, words 16'h4001/16'h4202/16'h0800 at 0/2/4 -> imem_req=1 one cycle after START. IF/ID shows 16'h4001 with pc_plus2=2, then 16'h4202 with pc_plus2=4, on consecutive cycles.
- Stall asserted in the cycle 16'hC0FF returns from addr 6 -> IF/ID holds its prior instruction, imem_req=0, state=BUFFERED. Deasserting stall loads 16'hC0FF with pc_plus2=8, then fetch resumes at 8.
- imem_ready low for 3 cycles at addr 10 -> imem_addr stays 10, imem_req stays 1, IF/ID valid=0 for 3 cycles, then the instruction arrives with pc_plus2=12.
- HALT (16'h0000) fetched at 20 -> halted=1 and imem_req=0 from the next cycle. redirect with redirect_pc=16'h0040 -> halted=0 and fetch resumes at 16'h0040.
- redirect, stall and imem_ready all high in the same cycle (redirect_pc=16'h0100) -> returned word discarded, IF/ID valid=0, skid buffer empty, next imem_addr=16'h0100.
- PC at 16'hFFFE, ready -> if_id_pc_plus2=16'h0000 and next imem_addr=16'h0000. Asserting rst_n low mid-wait -> outputs reach reset values without a clock edge.
